// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and byte-level helpers.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, PRESENT, SUB, MIX} ks_state_t;

   localparam int         AES_NR     = 10;
   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] XTIME_POLY = 8'h1b;

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Round-key handshake bundle between the key loader and the cipher round controller.
interface key_schedule_ctrl_if;

   logic         start;
   logic [127:0] key;
   logic         next;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         rk_valid;
   logic         busy;
   logic         done;

   modport master (
      output start, key, next,
      input  round_key, round_idx, rk_valid, busy, done
   );

   modport slave (
      input  start, key, next,
      output round_key, round_idx, rk_valid, busy, done
   );

endinterface

// File: rtl/rot_word.sv
// RotWord byte rotation: [b0,b1,b2,b3] -> [b1,b2,b3,b0], passes through when disabled.
module rot_word (
   input  logic        en,
   input  logic [31:0] word,
   output logic [31:0] rotated
);

   assign rotated = en ? {word[23:0], word[31:24]} : word;

endmodule

// File: rtl/sub_word_sync.sv
// SubWord with one cycle of registered latency: four parallel S-box lookups.
module sub_word_sync
   import aes_pkg::*;
(
   input  logic        clk,
   input  logic [31:0] word,
   output logic [31:0] sub
);

   always_ff @(posedge clk) begin
      sub <= {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
   end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion sequencer: presents round keys 0..NUM_ROUNDS one at a
// time, computing each step on demand from the previous round key.
module key_schedule_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NR
)(
   input  logic                clk,
   input  logic                reset,
   key_schedule_ctrl_if.slave  bus
);

   ks_state_t    state, state_next;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic [7:0]   rcon;
   logic         done_q;
   logic         load, finish, last;
   logic [31:0]  rot_out, sub_out, temp;
   logic [31:0]  w0n, w1n, w2n, w3n;

   // round_key is stable for the whole SUB wait, so the S-box input needs no gating.
   rot_word u_rot (
      .en      (1'b1),
      .word    (round_key[31:0]),
      .rotated (rot_out)
   );

   sub_word_sync u_sub (
      .clk  (clk),
      .word (rot_out),
      .sub  (sub_out)
   );

   assign last = (round_idx == 4'(NUM_ROUNDS));

   always_comb begin
      temp = sub_out ^ {rcon, 24'h0};
      w0n  = round_key[127:96] ^ temp;
      w1n  = round_key[95:64]  ^ w0n;
      w2n  = round_key[63:32]  ^ w1n;
      w3n  = round_key[31:0]   ^ w2n;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Blocking start while done is high gives the consumer one clean idle cycle.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      finish     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start && !done_q) begin
               load       = 1'b1;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.next) begin
               if (last) begin
                  finish     = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = SUB;
               end
            end
         end
         SUB:     state_next = MIX;
         MIX:     state_next = PRESENT;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         round_key <= '0;
         round_idx <= '0;
         rcon      <= RCON_INIT;
         done_q    <= 1'b0;
      end else begin
         done_q <= finish;
         if (load) begin
            round_key <= bus.key;
            round_idx <= '0;
            rcon      <= RCON_INIT;
         end else if (state == MIX) begin
            round_key <= {w0n, w1n, w2n, w3n};
            round_idx <= round_idx + 4'd1;
            rcon      <= xtime(rcon);
         end
      end
   end

   assign bus.round_key = round_key;
   assign bus.round_idx = round_idx;
   assign bus.rk_valid  = (state == PRESENT);
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a word-level FIPS-197 key expansion model.
module tb_key_schedule_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   key_schedule_ctrl_if bus ();

   key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]   sboxModel [256];
   logic [127:0] expKeys   [11];
   logic [7:0]   rconModel [11];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   task automatic buildSbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sboxModel[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic buildSchedule(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sboxModel[t[31:24]], sboxModel[t[23:16]], sboxModel[t[15:8]], sboxModel[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rconModel[i/4] = rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) expKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [127:0] k, input logic n);
      bus.start = s;
      bus.key   = k;
      bus.next  = n;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkPresent(input string tag, input int r);
      checkOutput($sformatf("%s key r%0d", tag, r), bus.round_key, expKeys[r]);
      checkOutput($sformatf("%s idx r%0d", tag, r), 128'(bus.round_idx), 128'(r));
      checkOutput($sformatf("%s valid r%0d", tag, r), 128'(bus.rk_valid), 128'(1));
   endtask

   function automatic logic [127:0] randKey();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Full schedule with randomised backpressure; optional forced hold at one round.
   task automatic runSchedule(input logic [127:0] k, input int holdRound, input int holdCycles,
                              input bit checkRcon);
      int hold;
      buildSchedule(k);
      applyStimulus(1'b1, k, 1'b0);
      step();
      applyStimulus(1'b0, randKey(), 1'b0);
      for (int r = 0; r <= 10; r++) begin
         checkPresent("sched", r);
         if (checkRcon && (r == 8 || r == 9))
            checkOutput($sformatf("rcon r%0d", r), 128'(dut.rcon), 128'(rconModel[r+1]));
         hold = (r == holdRound) ? holdCycles : int'($urandom_range(0, 2));
         for (int h = 0; h < hold; h++) begin
            step();
            checkPresent("hold", r);
         end
         bus.next = 1'b1;
         step();
         bus.next = 1'b0;
         if (r < 10) begin
            checkOutput($sformatf("valid drop r%0d", r), 128'(bus.rk_valid), 128'(0));
            checkOutput($sformatf("no done r%0d", r), 128'(bus.done), 128'(0));
            step();
            checkOutput($sformatf("valid gap r%0d", r), 128'(bus.rk_valid), 128'(0));
            step();
         end else begin
            checkOutput("done pulse", 128'(bus.done), 128'(1));
            checkOutput("busy after done", 128'(bus.busy), 128'(0));
            checkOutput("valid after done", 128'(bus.rk_valid), 128'(0));
         end
      end
      step();
      checkOutput("done single", 128'(bus.done), 128'(0));
      checkOutput("key held idle", bus.round_key, expKeys[10]);
   endtask

   initial begin
      int cnt;
      int expR;
      logic [127:0] k2;

      $display("[TB] building reference S-box");
      buildSbox();

      // Reset state
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      repeat (3) step();
      checkOutput("reset valid", 128'(bus.rk_valid), 128'(0));
      checkOutput("reset busy", 128'(bus.busy), 128'(0));
      checkOutput("reset done", 128'(bus.done), 128'(0));
      checkOutput("reset idx", 128'(bus.round_idx), 128'(0));
      checkOutput("reset key", bus.round_key, 128'(0));
      checkOutput("reset rcon", 128'(dut.rcon), 128'(8'h01));
      reset = 1'b0;
      step();

      // next while idle must not start anything
      applyStimulus(1'b0, FIPS_KEY, 1'b1);
      step();
      checkOutput("idle next busy", 128'(bus.busy), 128'(0));
      bus.next = 1'b0;

      // FIPS-197 directed rounds 1 and 2, then reset in MIX
      buildSchedule(FIPS_KEY);
      applyStimulus(1'b1, FIPS_KEY, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("fips r0", bus.round_key, FIPS_KEY);
      bus.next = 1'b1; step(); bus.next = 1'b0;
      step(); step();
      checkOutput("fips r1", bus.round_key, 128'ha0fafe1788542cb123a339392a6c7605);
      bus.next = 1'b1; step(); bus.next = 1'b0;
      step(); step();
      checkOutput("fips r2", bus.round_key, 128'hf2c295f27a96b9435935807a7359f67f);
      bus.next = 1'b1; step(); bus.next = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("mixrst valid", 128'(bus.rk_valid), 128'(0));
      checkOutput("mixrst busy", 128'(bus.busy), 128'(0));
      checkOutput("mixrst idx", 128'(bus.round_idx), 128'(0));
      checkOutput("mixrst key", bus.round_key, 128'(0));

      // Full FIPS schedule with 7-cycle backpressure at round 4
      runSchedule(FIPS_KEY, 4, 7, 1'b0);
      checkOutput("fips r10", bus.round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Rcon wrap with all-zero key
      runSchedule(128'h0, -1, 0, 1'b1);

      // Illegal start/next while busy
      k2 = randKey();
      buildSchedule(k2);
      applyStimulus(1'b1, k2, 1'b0);
      step();
      checkPresent("illegal", 0);
      applyStimulus(1'b1, ~k2, 1'b0);
      step();
      checkPresent("start in present", 0);
      applyStimulus(1'b0, ~k2, 1'b1);
      step();
      applyStimulus(1'b1, ~k2, 1'b1);
      step();
      checkOutput("mix busy", 128'(bus.busy), 128'(1));
      checkOutput("mix valid", 128'(bus.rk_valid), 128'(0));
      step();
      applyStimulus(1'b0, ~k2, 1'b0);
      checkPresent("after illegal", 1);
      step();
      checkPresent("no advance", 1);
      reset = 1'b1;
      step();
      reset = 1'b0;

      // next held high: start and next together, 3-cycle spacing, done at 31
      k2 = randKey();
      buildSchedule(k2);
      applyStimulus(1'b1, k2, 1'b1);
      step();
      bus.start = 1'b0;
      checkPresent("flat", 0);
      cnt  = 0;
      expR = 1;
      while (cnt < 100) begin
         step();
         cnt++;
         if (bus.rk_valid) begin
            checkOutput($sformatf("spacing r%0d", expR), 128'(cnt), 128'(3 * expR));
            if (expR <= 10) checkPresent("flat", expR);
            expR++;
         end
         if (bus.done) break;
      end
      checkOutput("done latency", 128'(cnt), 128'(31));
      checkOutput("flat rounds", 128'(expR), 128'(11));

      // start during the done cycle is ignored, accepted the cycle after
      applyStimulus(1'b1, ~k2, 1'b0);
      step();
      checkOutput("done-cycle start busy", 128'(bus.busy), 128'(0));
      checkOutput("done-cycle key held", bus.round_key, expKeys[10]);
      step();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("restart valid", 128'(bus.rk_valid), 128'(1));
      checkOutput("restart key", bus.round_key, ~k2);
      checkOutput("restart idx", 128'(bus.round_idx), 128'(0));
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();

      // Random keys with random backpressure
      for (int n = 0; n < 3; n++) runSchedule(randKey(), -1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
